// File: rtl/fetch_stage_pkg.sv
// Shared fetch-side definitions: fetch FSM encoding, text-segment defaults, instruction width.
package fetch_stage_pkg;

   localparam int unsigned INSTR_W           = 32;
   localparam logic [31:0] DEF_TEXT_BASE     = 32'h0040_0000;
   localparam logic [31:0] DEF_RESET_PC      = 32'h0040_0000;
   localparam int unsigned DEF_TEXT_WORDS    = 256;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_range_check.sv
// Pure combinational legality check of a word address against the text segment.
// The bounds are compared in 33 bits, so a segment ending at 4 GiB cannot wrap to zero.
module fetch_stage_pc_range_check
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
   parameter int unsigned TEXT_WORDS = DEF_TEXT_WORDS
) (
   input  logic [31:0] i_pc,
   output logic        o_bad
);

   localparam logic [32:0] LO_BOUND = {1'b0, TEXT_BASE};
   localparam logic [32:0] HI_BOUND = LO_BOUND + (33'(TEXT_WORDS) * 33'd4);

   logic [32:0] w_pc33;

   assign w_pc33 = {1'b0, i_pc};
   assign o_bad  = (i_pc[1:0] != 2'b00) || (w_pc33 < LO_BOUND) || (w_pc33 >= HI_BOUND);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the fetch address and captures the returned word into IF/ID.
// A bad PC in RUN latches a sticky fault and freezes fetch until reset.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
   parameter int unsigned TEXT_WORDS = DEF_TEXT_WORDS
) (
   input  logic               clock,
   input  logic               clear_n,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_target,
   output logic [31:0]        mem_addr,
   input  logic [INSTR_W-1:0] mem_instr,
   output logic               if_id_valid,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [31:0]        if_id_pc,
   output logic [31:0]        if_id_pc_plus4,
   output logic               fault,
   output logic [31:0]        fault_pc,
   output logic [31:0]        fetch_count
);

   fetch_state_e       r_state;
   fetch_state_e       w_state_nxt;
   logic [31:0]        r_pc;
   logic               r_if_id_valid;
   logic [INSTR_W-1:0] r_if_id_instr;
   logic [31:0]        r_if_id_pc;
   logic [31:0]        r_if_id_pc_plus4;
   logic               r_fault;
   logic [31:0]        r_fault_pc;
   logic [31:0]        r_fetch_count;

   logic               w_bad_pc;
   logic [31:0]        w_pc_plus4;
   logic               w_capture;
   logic               w_redirect;
   logic               w_take_fault;

   fetch_stage_pc_range_check #(
      .TEXT_BASE  (TEXT_BASE),
      .TEXT_WORDS (TEXT_WORDS)
   ) u_pc_check (
      .i_pc  (r_pc),
      .o_bad (w_bad_pc)
   );

   assign w_pc_plus4 = r_pc + 32'd4;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) r_state <= ST_BOOT;
      else          r_state <= w_state_nxt;
   end

   // Priority in RUN: bad PC, then redirect (which beats stall), then stall, then capture.
   always_comb begin
      w_state_nxt  = r_state;
      w_capture    = 1'b0;
      w_redirect   = 1'b0;
      w_take_fault = 1'b0;
      case (r_state)
         ST_BOOT: w_state_nxt = ST_RUN;
         ST_RUN: begin
            if (w_bad_pc) begin
               w_state_nxt  = ST_FAULT;
               w_take_fault = 1'b1;
            end else if (redirect_valid) begin
               w_redirect = 1'b1;
            end else if (!stall) begin
               w_capture = 1'b1;
            end
         end
         ST_FAULT: w_state_nxt = ST_FAULT;
         default:  w_state_nxt = ST_BOOT;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_pc             <= RESET_PC;
         r_if_id_valid    <= 1'b0;
         r_if_id_instr    <= '0;
         r_if_id_pc       <= '0;
         r_if_id_pc_plus4 <= '0;
         r_fault          <= 1'b0;
         r_fault_pc       <= '0;
         r_fetch_count    <= '0;
      end else begin
         if (w_redirect)
            r_pc <= redirect_target;
         else if (w_capture)
            r_pc <= w_pc_plus4;

         if (w_take_fault || w_redirect)
            r_if_id_valid <= 1'b0;
         else if (w_capture)
            r_if_id_valid <= 1'b1;

         if (w_capture) begin
            r_if_id_instr    <= mem_instr;
            r_if_id_pc       <= r_pc;
            r_if_id_pc_plus4 <= w_pc_plus4;
            r_fetch_count    <= r_fetch_count + 32'd1;
         end

         if (w_take_fault) begin
            r_fault    <= 1'b1;
            r_fault_pc <= r_pc;
         end
      end
   end

   assign mem_addr       = r_pc;
   assign if_id_valid    = r_if_id_valid;
   assign if_id_instr    = r_if_id_instr;
   assign if_id_pc       = r_if_id_pc;
   assign if_id_pc_plus4 = r_if_id_pc_plus4;
   assign fault          = r_fault;
   assign fault_pc       = r_fault_pc;
   assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns address ^ 32'hDEAD_BEEF.
module tb_fetch_stage;

   logic        clock;
   logic        clear_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] mem_addr;
   logic [31:0] mem_instr;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   fetch_stage dut (
      .clock           (clock),
      .clear_n         (clear_n),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .mem_addr        (mem_addr),
      .mem_instr       (mem_instr),
      .if_id_valid     (if_id_valid),
      .if_id_instr     (if_id_instr),
      .if_id_pc        (if_id_pc),
      .if_id_pc_plus4  (if_id_pc_plus4),
      .fault           (fault),
      .fault_pc        (fault_pc),
      .fetch_count     (fetch_count)
   );

   function automatic logic [31:0] memword(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   assign mem_instr = memword(mem_addr);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      clear_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      #12;
      checks++; if (mem_addr !== 32'h0040_0000) begin errors++; $display("FAIL reset_mem_addr: got %h want %h", mem_addr, 32'h0040_0000); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
      checks++; if (if_id_instr !== 32'h0 || if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_if_id: got %h %h %h want zeros", if_id_instr, if_id_pc, if_id_pc_plus4); end
      checks++; if (fault !== 1'b0 || fault_pc !== 32'h0 || fetch_count !== 32'h0) begin errors++; $display("FAIL reset_fault_cnt: got %b %h %h want 0 0 0", fault, fault_pc, fetch_count); end
      clear_n = 1'b1;
      tick();
      checks++; if (if_id_valid !== 1'b0 || fetch_count !== 32'h0 || mem_addr !== 32'h0040_0000) begin errors++; $display("FAIL boot_no_capture: got v=%b cnt=%h addr=%h want 0 0 00400000", if_id_valid, fetch_count, mem_addr); end
   endtask

   task automatic test_free_run();
      logic [31:0] exp_pc;
      for (int i = 0; i < 3; i++) begin
         exp_pc = 32'h0040_0000 + 32'(4 * i);
         tick();
         checks++; if (if_id_valid !== 1'b1 || if_id_pc !== exp_pc || if_id_instr !== memword(exp_pc)) begin errors++; $display("FAIL free_run_%0d: got v=%b pc=%h instr=%h want 1 %h %h", i, if_id_valid, if_id_pc, if_id_instr, exp_pc, memword(exp_pc)); end
         checks++; if (if_id_pc_plus4 !== exp_pc + 32'd4 || fetch_count !== 32'(i + 1)) begin errors++; $display("FAIL free_run_p4cnt_%0d: got %h %0d want %h %0d", i, if_id_pc_plus4, fetch_count, exp_pc + 32'd4, i + 1); end
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (if_id_pc !== 32'h0040_0008 || fetch_count !== 32'd3 || mem_addr !== 32'h0040_000C || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_%0d: got pc=%h cnt=%0d addr=%h v=%b want 00400008 3 0040000c 1", i, if_id_pc, fetch_count, mem_addr, if_id_valid); end
      end
      stall = 1'b0;
      tick();
      checks++; if (if_id_pc !== 32'h0040_000C || if_id_instr !== memword(32'h0040_000C) || fetch_count !== 32'd4 || mem_addr !== 32'h0040_0010) begin errors++; $display("FAIL stall_release: got pc=%h instr=%h cnt=%0d addr=%h", if_id_pc, if_id_instr, fetch_count, mem_addr); end
   endtask

   task automatic test_redirect_over_stall();
      stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0040_0040;
      tick();
      stall = 1'b0; redirect_valid = 1'b0;
      checks++; if (mem_addr !== 32'h0040_0040 || if_id_valid !== 1'b0 || fetch_count !== 32'd4) begin errors++; $display("FAIL redirect_flush: got addr=%h v=%b cnt=%0d want 00400040 0 4", mem_addr, if_id_valid, fetch_count); end
      tick();
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0040_0040 || if_id_instr !== memword(32'h0040_0040) || if_id_pc_plus4 !== 32'h0040_0044 || fetch_count !== 32'd5) begin errors++; $display("FAIL redirect_capture: got v=%b pc=%h instr=%h p4=%h cnt=%0d", if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus4, fetch_count); end
   endtask

   task automatic test_misaligned();
      redirect_valid = 1'b1; redirect_target = 32'h0040_0042;
      tick();
      redirect_valid = 1'b0;
      checks++; if (mem_addr !== 32'h0040_0042 || fault !== 1'b0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL misalign_load: got addr=%h fault=%b v=%b want 00400042 0 0", mem_addr, fault, if_id_valid); end
      tick();
      checks++; if (fault !== 1'b1 || fault_pc !== 32'h0040_0042 || if_id_valid !== 1'b0 || fetch_count !== 32'd5) begin errors++; $display("FAIL misalign_fault: got fault=%b fpc=%h v=%b cnt=%0d want 1 00400042 0 5", fault, fault_pc, if_id_valid, fetch_count); end
      redirect_valid = 1'b1; redirect_target = 32'h0040_0000;
      tick();
      tick();
      redirect_valid = 1'b0;
      checks++; if (mem_addr !== 32'h0040_0042 || fault !== 1'b1 || fault_pc !== 32'h0040_0042 || if_id_valid !== 1'b0 || fetch_count !== 32'd5) begin errors++; $display("FAIL fault_frozen: got addr=%h fault=%b fpc=%h v=%b cnt=%0d", mem_addr, fault, fault_pc, if_id_valid, fetch_count); end
   endtask

   task automatic test_clear_in_fault();
      #2 clear_n = 1'b0;
      #1;
      checks++; if (fault !== 1'b0 || fault_pc !== 32'h0 || mem_addr !== 32'h0040_0000 || fetch_count !== 32'h0) begin errors++; $display("FAIL async_clear: got fault=%b fpc=%h addr=%h cnt=%h", fault, fault_pc, mem_addr, fetch_count); end
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0) begin errors++; $display("FAIL async_clear_if_id: got v=%b instr=%h pc=%h", if_id_valid, if_id_instr, if_id_pc); end
      clear_n = 1'b1;
      tick();
      checks++; if (if_id_valid !== 1'b0 || fetch_count !== 32'h0 || mem_addr !== 32'h0040_0000) begin errors++; $display("FAIL clear_boot: got v=%b cnt=%h addr=%h", if_id_valid, fetch_count, mem_addr); end
      tick();
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0040_0000 || fetch_count !== 32'd1) begin errors++; $display("FAIL clear_run: got v=%b pc=%h cnt=%0d want 1 00400000 1", if_id_valid, if_id_pc, fetch_count); end
   endtask

   task automatic test_run_off_end();
      int n;
      n = 0;
      while (fault !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL run_off_end_timeout: fault=%b after %0d cycles, want 1", fault, n); end
      checks++; if (fault_pc !== 32'h0040_0400 || fetch_count !== 32'd256) begin errors++; $display("FAIL run_off_end: got fpc=%h cnt=%0d want 00400400 256", fault_pc, fetch_count); end
      checks++; if (if_id_pc !== 32'h0040_03FC || if_id_valid !== 1'b0 || mem_addr !== 32'h0040_0400) begin errors++; $display("FAIL last_legal: got pc=%h v=%b addr=%h want 004003fc 0 00400400", if_id_pc, if_id_valid, mem_addr); end
   endtask

   task automatic test_below_base();
      #2 clear_n = 1'b0;
      #2 clear_n = 1'b1;
      tick();
      redirect_valid = 1'b1; redirect_target = 32'h003F_FFFC;
      tick();
      redirect_valid = 1'b0;
      checks++; if (fault !== 1'b0 || mem_addr !== 32'h003F_FFFC) begin errors++; $display("FAIL below_base_load: got fault=%b addr=%h want 0 003ffffc", fault, mem_addr); end
      tick();
      checks++; if (fault !== 1'b1 || fault_pc !== 32'h003F_FFFC || fetch_count !== 32'h0) begin errors++; $display("FAIL below_base_fault: got fault=%b fpc=%h cnt=%0d want 1 003ffffc 0", fault, fault_pc, fetch_count); end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_redirect_over_stall();
      test_misaligned();
      test_clear_in_fault();
      test_run_off_end();
      test_below_base();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
